// File: rtl/pixcapture_if.sv
// -----------------------------------------------------------------------------
// pixcapture_if
// Wishbone classic-pipelined slave bus used by pixcapture.
//   i_wb_cyc/stb/we  : cycle, strobe and write-enable from the bus master
//   i_wb_addr        : word address; MSB=1 selects the capture buffer,
//                      MSB=0 selects the control registers (low 2 bits)
//   i_wb_data        : write data
//   o_wb_stall       : never asserted
//   o_wb_ack         : registered acknowledge, one cycle after each strobe
//   o_wb_data        : read data, valid in the acknowledge cycle
// Port-direction prefixes are from the slave's point of view.
// -----------------------------------------------------------------------------
interface pixcapture_if #(
   parameter int LGDEPTH = 4
) ();
   logic               i_wb_cyc;
   logic               i_wb_stb;
   logic               i_wb_we;
   logic [LGDEPTH:0]   i_wb_addr;
   logic [31:0]        i_wb_data;
   logic               o_wb_stall;
   logic               o_wb_ack;
   logic [31:0]        o_wb_data;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      input  o_wb_stall, o_wb_ack, o_wb_data
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      output o_wb_stall, o_wb_ack, o_wb_data
   );
endinterface

// File: rtl/pixcapture.sv
// -----------------------------------------------------------------------------
// pixcapture
// Pixel-snoop debug peripheral. Watches a qualified pixel stream and, after a
// programmable pixel delay from frame sync, stores a window of up to 2^LGDEPTH
// pixels (optionally decimated by a stride) into a local buffer readable over
// Wishbone. Single-shot or continuous (re-arm each frame); o_int pulses once
// per completed capture.
// Ports:
//   i_clk, i_reset_n : sole clock, asynchronous active-low reset
//   wb               : Wishbone slave (see pixcapture_if)
//   i_pix_valid      : pixel qualifier
//   i_pix_sync       : first pixel of frame (only meaningful with valid)
//   i_pix_data       : pixel value
//   o_int            : one-cycle pulse when a capture completes
// Register map (address MSB=0): 0 CTRL/STATUS, 1 DELAY, 2 LENGTH, 3 STRIDE.
// Requires 2 <= LGDEPTH <= 27.
// -----------------------------------------------------------------------------
module pixcapture #(
   parameter int DW      = 24,
   parameter int LGDEPTH = 4
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   pixcapture_if.slave   wb,
   input  logic          i_pix_valid,
   input  logic          i_pix_sync,
   input  logic [DW-1:0] i_pix_data,
   output logic          o_int
);
   localparam int            CW      = LGDEPTH + 1;
   localparam int            DEPTH   = 1 << LGDEPTH;
   localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_DELAY, S_CAPTURE, S_DONE
   } state_t;

   state_t         state_q, state_d;

   // Software-visible configuration and their per-arm shadow copies
   logic [31:0]    delay_q, sh_delay_q;
   logic [CW-1:0]  length_q, sh_length_q, length_eff;
   logic [15:0]    stride_q, sh_stride_q;
   logic           cont_q;

   logic [31:0]    index_q, index_d, index_inc;
   logic [15:0]    skip_q, skip_d;
   logic [CW-1:0]  count_q, count_inc, issued;
   logic           pend_q;
   logic [DW-1:0]  pend_data_q;
   logic           done_q, short_q, int_q, ack_q;
   logic [31:0]    rdata_q;
   logic [DW-1:0]  buf_mem [0:DEPTH-1];

   logic           bus_stb, reg_wr, ctrl_wr, arm_cmd, abort_cmd;
   logic           capture, load, set_short, finish, busy, int_d;
   logic [31:0]    status_word, rd_word;

   assign bus_stb   = wb.i_wb_cyc & wb.i_wb_stb;
   assign reg_wr    = bus_stb & wb.i_wb_we & ~wb.i_wb_addr[LGDEPTH];
   assign ctrl_wr   = reg_wr & (wb.i_wb_addr[1:0] == 2'd0);
   // ABORT takes priority over ARM within one CTRL write
   assign abort_cmd = ctrl_wr & wb.i_wb_data[2];
   assign arm_cmd   = ctrl_wr & wb.i_wb_data[0] & ~wb.i_wb_data[2];

   assign length_eff = (length_q == '0 || length_q > DEPTH_W) ? DEPTH_W : length_q;
   assign index_inc  = (index_q == '1) ? index_q : index_q + 32'd1;
   assign count_inc  = count_q + CW'(1);
   // Captures issued so far: landed in the buffer plus the one in flight
   assign issued     = count_q + CW'(pend_q);
   assign finish     = pend_q && (count_inc == sh_length_q);
   assign busy       = (state_q == S_ARMED) || (state_q == S_DELAY) ||
                       (state_q == S_CAPTURE);

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      skip_d    = skip_q;
      capture   = 1'b0;
      load      = 1'b0;
      set_short = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm_cmd || (state_q == S_DONE && cont_q)) begin
               state_d = S_ARMED;
               load    = 1'b1;
            end
         end
         S_ARMED: begin
            if (i_pix_valid && i_pix_sync) begin
               index_d = '0;
               skip_d  = sh_stride_q;
               if (sh_delay_q == '0) begin
                  capture = 1'b1;
                  state_d = S_CAPTURE;
               end else begin
                  state_d = S_DELAY;
               end
            end
         end
         S_DELAY: begin
            if (i_pix_valid) begin
               if (i_pix_sync) begin
                  // A new frame restarts the delay count (delay is non-zero here)
                  index_d = '0;
               end else begin
                  index_d = index_inc;
                  if (index_inc == sh_delay_q) begin
                     capture = 1'b1;
                     state_d = S_CAPTURE;
                  end
               end
            end
         end
         S_CAPTURE: begin
            if (finish) begin
               state_d = S_DONE;
            end else if (i_pix_valid && i_pix_sync) begin
               state_d   = S_DONE;
               set_short = 1'b1;
            end else if (i_pix_valid) begin
               if (skip_q != '0) begin
                  skip_d = skip_q - 16'd1;
               end else if (issued < sh_length_q) begin
                  capture = 1'b1;
                  skip_d  = sh_stride_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort_cmd) begin
         state_d   = S_IDLE;
         capture   = 1'b0;
         load      = 1'b0;
         set_short = 1'b0;
      end
   end

   assign int_d = (state_q == S_CAPTURE) && (state_d == S_DONE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= S_IDLE;
         delay_q     <= '0;
         length_q    <= DEPTH_W;
         stride_q    <= '0;
         cont_q      <= 1'b0;
         sh_delay_q  <= '0;
         sh_length_q <= DEPTH_W;
         sh_stride_q <= '0;
         index_q     <= '0;
         skip_q      <= '0;
         count_q     <= '0;
         pend_q      <= 1'b0;
         pend_data_q <= '0;
         done_q      <= 1'b0;
         short_q     <= 1'b0;
         int_q       <= 1'b0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         skip_q  <= skip_d;
         int_q   <= int_d;
         ack_q   <= bus_stb;
         if (bus_stb) rdata_q <= rd_word;

         if (reg_wr) begin
            case (wb.i_wb_addr[1:0])
               2'd0: cont_q   <= wb.i_wb_data[1];
               2'd1: delay_q  <= wb.i_wb_data;
               2'd2: length_q <= wb.i_wb_data[CW-1:0];
               2'd3: stride_q <= wb.i_wb_data[15:0];
               default: ;
            endcase
         end

         if (load) begin
            sh_delay_q  <= delay_q;
            sh_length_q <= length_eff;
            sh_stride_q <= stride_q;
         end

         // A chosen capture is written and counted one edge later
         pend_q <= capture;
         if (capture) pend_data_q <= i_pix_data;

         if (load)        count_q <= '0;
         else if (pend_q) count_q <= count_inc;

         if (load)       done_q <= 1'b0;
         else if (int_d) done_q <= 1'b1;

         if (load)           short_q <= 1'b0;
         else if (set_short) short_q <= 1'b1;
      end
   end

   // NOTE: the capture buffer has no reset; its contents are undefined until
   // written, which keeps it mappable onto plain RAM.
   always_ff @(posedge i_clk) begin
      if (pend_q) buf_mem[count_q[LGDEPTH-1:0]] <= pend_data_q;
   end

   always_comb begin
      status_word         = '0;
      status_word[31]     = busy;
      status_word[30]     = done_q;
      status_word[29]     = short_q;
      status_word[28]     = cont_q;
      status_word[CW-1:0] = count_q;
   end

   always_comb begin
      rd_word = '0;
      if (wb.i_wb_addr[LGDEPTH]) begin
         rd_word[DW-1:0] = buf_mem[wb.i_wb_addr[LGDEPTH-1:0]];
      end else begin
         case (wb.i_wb_addr[1:0])
            2'd0: rd_word = status_word;
            2'd1: rd_word = delay_q;
            2'd2: rd_word[CW-1:0] = length_q;
            2'd3: rd_word[15:0] = stride_q;
            default: ;
         endcase
      end
   end

   assign wb.o_wb_stall = 1'b0;
   assign wb.o_wb_ack   = ack_q;
   assign wb.o_wb_data  = rdata_q;
   assign o_int         = int_q;
endmodule

// File: tb/tb_pixcapture.sv
// -----------------------------------------------------------------------------
// tb_pixcapture
// Self-checking bench for pixcapture. Expected read results are pushed to a
// queue as stimulus is driven and popped when the bus returns data.
// -----------------------------------------------------------------------------
module tb_pixcapture;
   localparam int DW      = 24;
   localparam int LGDEPTH = 4;
   localparam int DEPTH   = 1 << LGDEPTH;

   localparam logic [LGDEPTH:0] A_CTRL   = 5'h00;
   localparam logic [LGDEPTH:0] A_DELAY  = 5'h01;
   localparam logic [LGDEPTH:0] A_LENGTH = 5'h02;
   localparam logic [LGDEPTH:0] A_STRIDE = 5'h03;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pix_valid = 1'b0;
   logic          pix_sync = 1'b0;
   logic [DW-1:0] pix_data = '0;
   logic          o_int;

   always #5 clk = ~clk;

   pixcapture_if #(.LGDEPTH(LGDEPTH)) wb ();

   pixcapture #(.DW(DW), .LGDEPTH(LGDEPTH)) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .wb          (wb),
      .i_pix_valid (pix_valid),
      .i_pix_sync  (pix_sync),
      .i_pix_data  (pix_data),
      .o_int       (o_int)
   );

   int          n_tests   = 0;
   int          n_fail    = 0;
   int          int_cnt   = 0;
   int          stall_bad = 0;
   logic [31:0] exp_q[$];

   always @(negedge clk) begin
      if (o_int === 1'b1) int_cnt++;
      if (wb.o_wb_stall !== 1'b0) stall_bad++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [LGDEPTH:0] buf_addr(input int i);
      return {1'b1, LGDEPTH'(i)};
   endfunction

   task automatic bus_write(input logic [LGDEPTH:0] a, input logic [31:0] d);
      wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = 1'b1;
      wb.i_wb_addr = a; wb.i_wb_data = d;
      @(posedge clk); #1;
      wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
   endtask

   task automatic bus_read(input logic [LGDEPTH:0] a, output logic [31:0] d,
                           output int lat);
      wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = 1'b0;
      wb.i_wb_addr = a;
      @(posedge clk); #1;
      wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0;
      lat = 1;
      while (wb.o_wb_ack !== 1'b1 && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      d = wb.o_wb_data;
   endtask

   task automatic pix(input logic v, input logic s, input logic [DW-1:0] d);
      pix_valid = v; pix_sync = s; pix_data = d;
      @(posedge clk); #1;
      pix_valid = 1'b0; pix_sync = 1'b0;
   endtask

   // Idle cycles carry sync=1 with valid=0 and junk data: none of it may count
   task automatic idle(input int n);
      repeat (n) begin
         pix_valid = 1'b0; pix_sync = 1'b1; pix_data = 24'hABCDEF;
         @(posedge clk); #1;
      end
      pix_sync = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d, e;
      int lat;
      wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
      wb.i_wb_addr = '0; wb.i_wb_data = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (wb.o_wb_ack !== 1'b0 || wb.o_wb_data !== 32'd0 || o_int !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: ack=%b data=%h int=%b, want 0/0/0",
                  wb.o_wb_ack, wb.o_wb_data, o_int);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'(DEPTH));
      exp_q.push_back(32'd0);
      for (int r = 0; r < 4; r++) begin
         bus_read(r[LGDEPTH:0], d, lat);
         e = exp_q.pop_front();
         n_tests++;
         if (d !== e || lat != 1) begin
            n_fail++;
            $display("FAIL reset_reg%0d: got %h lat %0d, want %h lat 1", r, d, lat, e);
         end
      end
   endtask

   task automatic test_delay_capture();
      logic [31:0] d, e;
      int lat, i0;
      bus_write(A_DELAY, 32'd5);
      bus_write(A_LENGTH, 32'd4);
      bus_write(A_STRIDE, 32'd0);
      i0 = int_cnt;
      bus_write(A_CTRL, 32'd1);
      for (int i = 0; i < 12; i++) begin
         if (i >= 5 && i <= 8) exp_q.push_back(32'(i));
         pix(1'b1, i == 0, DW'(i));
      end
      idle(3);
      n_tests++;
      if (int_cnt - i0 != 1) begin
         n_fail++;
         $display("FAIL delay_int: got %0d pulses, want 1", int_cnt - i0);
      end
      for (int i = 0; i < 4; i++) begin
         bus_read(buf_addr(i), d, lat);
         e = exp_q.pop_front();
         n_tests++;
         if (d !== e) begin
            n_fail++;
            $display("FAIL delay_buf%0d: got %h, want %h", i, d, e);
         end
      end
      exp_q.push_back(32'h4000_0004);
      bus_read(A_CTRL, d, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++;
         $display("FAIL delay_status: got %h, want %h", d, e);
      end
   endtask

   task automatic test_stride_gaps();
      logic [31:0] d, e;
      int lat, i0;
      bus_write(A_DELAY, 32'd0);
      bus_write(A_LENGTH, 32'd3);
      bus_write(A_STRIDE, 32'd2);
      i0 = int_cnt;
      bus_write(A_CTRL, 32'd1);
      idle(2);
      for (int i = 0; i < 10; i++) begin
         if (i % 3 == 0 && i <= 6) exp_q.push_back(32'(i));
         pix(1'b1, i == 0, DW'(i));
         if (i % 2 == 1) idle(1);
      end
      idle(3);
      n_tests++;
      if (int_cnt - i0 != 1) begin
         n_fail++;
         $display("FAIL stride_int: got %0d pulses, want 1", int_cnt - i0);
      end
      for (int i = 0; i < 3; i++) begin
         bus_read(buf_addr(i), d, lat);
         e = exp_q.pop_front();
         n_tests++;
         if (d !== e) begin
            n_fail++;
            $display("FAIL stride_buf%0d: got %h, want %h", i, d, e);
         end
      end
      exp_q.push_back(32'h4000_0003);
      bus_read(A_CTRL, d, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++;
         $display("FAIL stride_status: got %h, want %h", d, e);
      end
   endtask

   task automatic test_short_frame();
      logic [31:0] d, e;
      int lat, i0;
      bus_write(A_DELAY, 32'd0);
      bus_write(A_LENGTH, 32'd0);   // zero length means full depth
      bus_write(A_STRIDE, 32'd0);
      i0 = int_cnt;
      bus_write(A_CTRL, 32'd1);
      exp_q.push_back(32'd100);
      pix(1'b1, 1'b1, 24'd100);
      exp_q.push_back(32'd101);
      pix(1'b1, 1'b0, 24'd101);
      exp_q.push_back(32'd102);
      pix(1'b1, 1'b0, 24'd102);
      pix(1'b1, 1'b1, 24'd200);
      idle(3);
      n_tests++;
      if (int_cnt - i0 != 1) begin
         n_fail++;
         $display("FAIL short_int: got %0d pulses, want 1", int_cnt - i0);
      end
      for (int i = 0; i < 3; i++) begin
         bus_read(buf_addr(i), d, lat);
         e = exp_q.pop_front();
         n_tests++;
         if (d !== e) begin
            n_fail++;
            $display("FAIL short_buf%0d: got %h, want %h", i, d, e);
         end
      end
      exp_q.push_back(32'h6000_0003);
      bus_read(A_CTRL, d, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++;
         $display("FAIL short_status: got %h, want %h", d, e);
      end
   endtask

   task automatic test_arm_sync_miss();
      logic [31:0] d, e;
      int lat, i0;
      bus_write(A_DELAY, 32'd0);
      bus_write(A_LENGTH, 32'd1);
      i0 = int_cnt;
      // Sync on the ARM cycle must be missed
      pix_valid = 1'b1; pix_sync = 1'b1; pix_data = 24'h000111;
      bus_write(A_CTRL, 32'd1);
      pix_valid = 1'b0; pix_sync = 1'b0;
      pix(1'b1, 1'b0, 24'h000222);
      exp_q.push_back(32'h0000_0333);
      pix(1'b1, 1'b1, 24'h000333);
      idle(3);
      n_tests++;
      if (int_cnt - i0 != 1) begin
         n_fail++;
         $display("FAIL armsync_int: got %0d pulses, want 1", int_cnt - i0);
      end
      bus_read(buf_addr(0), d, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++;
         $display("FAIL armsync_buf0: got %h, want %h", d, e);
      end
      exp_q.push_back(32'h4000_0001);
      bus_read(A_CTRL, d, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++;
         $display("FAIL armsync_status: got %h, want %h", d, e);
      end
   endtask

   task automatic test_continuous();
      logic [31:0] d, e;
      int lat, i0;
      bus_write(A_DELAY, 32'd1);
      bus_write(A_LENGTH, 32'd2);
      bus_write(A_STRIDE, 32'd0);
      i0 = int_cnt;
      bus_write(A_CTRL, 32'd3);
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 4; i++) begin
            if (f == 2 && (i == 1 || i == 2)) exp_q.push_back(32'((f << 8) | i));
            pix(1'b1, i == 0, DW'((f << 8) | i));
         end
         idle(2);
      end
      n_tests++;
      if (int_cnt - i0 != 3) begin
         n_fail++;
         $display("FAIL cont_int: got %0d pulses, want 3", int_cnt - i0);
      end
      for (int i = 0; i < 2; i++) begin
         bus_read(buf_addr(i), d, lat);
         e = exp_q.pop_front();
         n_tests++;
         if (d !== e) begin
            n_fail++;
            $display("FAIL cont_buf%0d: got %h, want %h", i, d, e);
         end
      end
      // Re-armed for the next frame: busy with CONT set
      exp_q.push_back(32'h9000_0000);
      bus_read(A_CTRL, d, lat);
      e = exp_q.pop_front();
      n_tests++;
      if ((d & 32'hA000_0000) !== (e & 32'hA000_0000) || d[28] !== e[28]) begin
         n_fail++;
         $display("FAIL cont_status: got %h, want busy/cont bits of %h", d, e);
      end
      bus_write(A_CTRL, 32'd4);
      exp_q.push_back(32'h0000_0000);
      bus_read(A_CTRL, d, lat);
      e = exp_q.pop_front();
      n_tests++;
      if ((d & 32'hF000_0000) !== e) begin
         n_fail++;
         $display("FAIL cont_abort_status: got %h, want top bits %h", d, e);
      end
   endtask

   task automatic test_abort();
      logic [31:0] d, e;
      int lat, i0;
      bus_write(A_DELAY, 32'd20);
      bus_write(A_LENGTH, 32'd4);
      bus_write(A_STRIDE, 32'd0);
      i0 = int_cnt;
      bus_write(A_CTRL, 32'd1);
      for (int i = 0; i < 10; i++) pix(1'b1, i == 0, DW'(i));
      exp_q.push_back(32'h8000_0000);
      bus_read(A_CTRL, d, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++;
         $display("FAIL abort_busy: got %h, want %h", d, e);
      end
      bus_write(A_CTRL, 32'd5);   // ABORT with ARM: abort wins
      for (int i = 10; i < 30; i++) pix(1'b1, 1'b0, DW'(i));
      idle(2);
      exp_q.push_back(32'h0000_0000);
      bus_read(A_CTRL, d, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++;
         $display("FAIL abort_status: got %h, want %h", d, e);
      end
      n_tests++;
      if (int_cnt != i0) begin
         n_fail++;
         $display("FAIL abort_int: got %0d pulses, want 0", int_cnt - i0);
      end
   endtask

   task automatic test_reset_mid_capture();
      logic [31:0] d, e;
      int lat, i0;
      bus_write(A_DELAY, 32'd0);
      bus_write(A_LENGTH, 32'd0);
      bus_write(A_STRIDE, 32'd0);
      bus_write(A_CTRL, 32'd1);
      pix(1'b1, 1'b1, 24'h55);
      for (int i = 1; i < 4; i++) pix(1'b1, 1'b0, DW'(24'h55 + i));
      pix_valid = 1'b1; pix_data = 24'h77;
      wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = 1'b0; wb.i_wb_addr = A_CTRL;
      @(posedge clk); #1;
      wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0;
      n_tests++;
      if (wb.o_wb_ack !== 1'b1 || wb.o_wb_data[31] !== 1'b1) begin
         n_fail++;
         $display("FAIL midcap_busy: ack=%b data=%h, want ack 1 busy 1",
                  wb.o_wb_ack, wb.o_wb_data);
      end
      i0 = int_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (wb.o_wb_ack !== 1'b0 || wb.o_wb_data !== 32'd0 || o_int !== 1'b0) begin
         n_fail++;
         $display("FAIL midcap_async: ack=%b data=%h int=%b, want 0/0/0",
                  wb.o_wb_ack, wb.o_wb_data, o_int);
      end
      pix_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);
      n_tests++;
      if (int_cnt != i0) begin
         n_fail++;
         $display("FAIL midcap_int: got %0d pulses, want 0", int_cnt - i0);
      end
      exp_q.push_back(32'd0);
      bus_read(A_CTRL, d, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++;
         $display("FAIL midcap_status: got %h, want %h", d, e);
      end
      exp_q.push_back(32'(DEPTH));
      bus_read(A_LENGTH, d, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++;
         $display("FAIL midcap_length: got %h, want %h", d, e);
      end
   endtask

   initial begin
      test_reset();
      test_delay_capture();
      test_stride_gaps();
      test_short_frame();
      test_arm_sync_miss();
      test_continuous();
      test_abort();
      test_reset_mid_capture();
      n_tests++;
      if (stall_bad != 0) begin
         n_fail++;
         $display("FAIL stall: high on %0d cycles, want 0", stall_bad);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
